// File: rtl/if_unit_param.sv
`default_nettype none
// if_unit_param: SimpleRISC instruction-fetch unit driving a 1-cycle synchronous instruction
// memory, with stall hold, branch squash and a RUN/HALT controller.
module if_unit_param #(
    parameter int                PC_W        = 32,
    parameter int                INST_W      = 32,
    parameter int                IM_ADDR_W   = 7,
    parameter logic [PC_W-1:0]   RESET_PC    = '0,
    parameter logic [4:0]        HALT_OPCODE = 5'b11111
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 isBranchTaken,
    input  logic [PC_W-1:0]      branchPC,
    output logic [INST_W-1:0]    inst,
    output logic [PC_W-1:0]      pc,
    output logic                 inst_valid,
    output logic                 stop,
    output logic                 IMclka,
    output logic                 IMena,
    output logic [IM_ADDR_W-1:0] IMaddra,
    input  logic [INST_W-1:0]    IMdouta
);

    localparam logic       RUN    = 1'b0;
    localparam logic       HALT   = 1'b1;
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic              state;
    logic              next_state;
    logic [PC_W-1:0]   pc_f;
    logic [INST_W-1:0] hold_reg;
    logic              hold_valid;
    logic              running;
    logic              halt_hit;

    // The memory output only holds for one cycle, so a stalled instruction is parked in hold_reg.
    assign inst     = hold_valid ? hold_reg : IMdouta;
    assign IMclka   = clk;
    assign IMaddra  = pc_f[IM_ADDR_W-1:0];
    assign halt_hit = inst_valid && (inst[INST_W-1 -: 5] == HALT_OPCODE) && !stall && !isBranchTaken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (halt_hit) next_state = HALT;
            HALT:    next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        running = (state == RUN);
        IMena   = running && (!stall || isBranchTaken);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_f       <= RESET_PC;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            stop       <= 1'b0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
        end else if (running) begin
            if (isBranchTaken) begin
                pc_f       <= branchPC;
                inst_valid <= 1'b0;
                hold_valid <= 1'b0;
            end else if (halt_hit) begin
                inst_valid <= 1'b0;
                stop       <= 1'b1;
            end else if (stall) begin
                if (!hold_valid) begin
                    hold_reg   <= IMdouta;
                    hold_valid <= 1'b1;
                end
            end else begin
                pc         <= pc_f;
                pc_f       <= pc_f + PC_ONE;
                inst_valid <= 1'b1;
                hold_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_unit_param.sv
`default_nettype none
// Bench for if_unit_param: directed scenarios plus random stall/branch traffic checked
// against a decode-side behavioural model of the fetch stream.
module tb_if_unit_param;

    localparam int PC_W = 8;
    localparam int AW   = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [7:0]  bpc = '0;
    logic [31:0] inst;
    logic [7:0]  pc;
    logic        inst_valid, stop, im_clk, im_ena;
    logic [6:0]  im_addr;
    logic [31:0] im_dout;

    logic [31:0] mem [0:127];

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_en = 1'b0;
    int  m_fetch, m_pc, halt_cnt;
    bit  m_valid, m_halt;

    if_unit_param #(.PC_W(PC_W), .INST_W(32), .IM_ADDR_W(AW), .RESET_PC(8'h00),
                    .HALT_OPCODE(5'b11111)) dut (
        .clk(clk), .rst(rst), .stall(stall), .isBranchTaken(br), .branchPC(bpc),
        .inst(inst), .pc(pc), .inst_valid(inst_valid), .stop(stop),
        .IMclka(im_clk), .IMena(im_ena), .IMaddra(im_addr), .IMdouta(im_dout));

    always #5 clk = ~clk;

    // Synchronous-read memory; when not enabled its output turns to garbage so held data is exercised.
    always @(posedge clk) im_dout <= im_ena ? mem[im_addr] : $urandom;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("stop", stop, m_halt);
            check("inst_valid", inst_valid, m_valid);
            check("pc", pc, m_pc);
            check("IMena", im_ena, !m_halt && (!stall || br));
            check("IMaddra", im_addr, m_fetch % 128);
            if (m_valid) check("inst", inst, mem[m_pc % 128]);
        end
    end

    // Decode-side view: the stream of (pc, mem[pc]) handed over, one per accepted cycle.
    task automatic model_step(input bit s, input bit b, input logic [7:0] t);
        if (m_halt) begin
        end else if (b) begin
            m_fetch = t;
            m_valid = 1'b0;
        end else if (m_valid && mem[m_pc % 128][31:27] == 5'b11111 && !s) begin
            m_halt  = 1'b1;
            m_valid = 1'b0;
        end else if (!s) begin
            m_pc    = m_fetch;
            m_fetch = (m_fetch + 1) % 256;
            m_valid = 1'b1;
        end
    endtask

    task automatic cyc(input bit s, input bit b, input logic [7:0] t);
        stall = s;
        br    = b;
        bpc   = t;
        @(posedge clk);
        model_step(s, b, t);
        #1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        stall  = 1'b0;
        br     = 1'b0;
        rst    = 1'b0;
        m_fetch = 0; m_pc = 0; m_valid = 1'b0; m_halt = 1'b0; halt_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h100 + i;

        // Reset and streaming
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 8'h00);
            check("t1_pc", pc, i);
            check("t1_inst", inst, 32'h100 + i);
            check("t1_valid", inst_valid, 1'b1);
            check("t1_addr", im_addr, i + 1);
        end

        // Branch squash
        do_reset();
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        check("t2_pc_before", pc, 2);
        cyc(1'b0, 1'b1, 8'h40);
        check("t2_squash", inst_valid, 1'b0);
        check("t2_addr", im_addr, 7'h40);
        cyc(1'b0, 1'b0, 8'h00);
        check("t2_pc", pc, 8'h40);
        check("t2_inst", inst, 32'h140);
        check("t2_valid", inst_valid, 1'b1);

        // Stall hold
        do_reset();
        repeat (6) cyc(1'b0, 1'b0, 8'h00);
        check("t3_pc_before", pc, 5);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            check("t3_inst", inst, 32'h105);
            check("t3_pc", pc, 5);
            check("t3_valid", inst_valid, 1'b1);
            check("t3_ena", im_ena, 1'b0);
        end
        cyc(1'b0, 1'b0, 8'h00);
        check("t3_pc_after", pc, 6);
        check("t3_inst_after", inst, 32'h106);

        // Branch during stall
        cyc(1'b1, 1'b1, 8'h10);
        check("t4_squash", inst_valid, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        check("t4_pc", pc, 8'h10);
        check("t4_inst", inst, 32'h110);

        // Halt
        chk_en = 1'b0;
        mem[3] = 32'hF800_0000;
        do_reset();
        repeat (4) cyc(1'b0, 1'b0, 8'h00);
        check("t5_pc", pc, 3);
        check("t5_valid", inst_valid, 1'b1);
        check("t5_inst", inst, 32'hF800_0000);
        cyc(1'b0, 1'b0, 8'h00);
        check("t5_stop", stop, 1'b1);
        check("t5_valid_off", inst_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'(i % 3 == 1), 1'(i % 2 == 0), 8'($urandom));
            check("t5_stop_hold", stop, 1'b1);
            check("t5_pc_hold", pc, 3);
        end
        #2 chk_en = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_stop_clear", stop, 1'b0);
        check("t5_valid_clear", inst_valid, 1'b0);
        mem[3] = 32'h103;

        // Wrap and asynchronous reset
        do_reset();
        cyc(1'b0, 1'b1, 8'hFE);
        cyc(1'b0, 1'b0, 8'h00);
        check("t6_pc_fe", pc, 8'hFE);
        check("t6_inst_fe", inst, 32'h17E);
        cyc(1'b0, 1'b0, 8'h00);
        check("t6_pc_ff", pc, 8'hFF);
        cyc(1'b0, 1'b0, 8'h00);
        check("t6_pc_00", pc, 8'h00);
        check("t6_inst_00", inst, 32'h100);
        cyc(1'b0, 1'b0, 8'h00);
        #2 chk_en = 1'b0;
        rst = 1'b0;
        #1;
        check("t6_async_pc", pc, 8'h00);
        check("t6_async_valid", inst_valid, 1'b0);
        check("t6_async_addr", im_addr, 7'h00);
        check("t6_async_stop", stop, 1'b0);

        // Random stall/branch traffic, with one halt word reachable
        chk_en = 1'b0;
        mem[7'h55] = 32'hF800_0055;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) == 0), 8'($urandom));
            if (m_halt) begin
                halt_cnt++;
                if (halt_cnt > 4) do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
